// File: rtl/strobe_pulse_gen_if.sv
// Trigger/config/strobe bundle between the camera-rate generator and the strobe pulse stage.
// master drives trigger and configuration; slave (the pulse generator) returns strobe and status.
interface strobe_pulse_gen_if #(
    parameter int CNT_W  = 32,
    parameter int MISS_W = 16
);
    logic              trig_in;
    logic              enable;
    logic [15:0]       divisor;
    logic [CNT_W-1:0]  delay_cycles;
    logic [CNT_W-1:0]  width_cycles;
    logic              strobe_out;
    logic              busy;
    logic [MISS_W-1:0] missed_cnt;

    modport master (
        output trig_in, enable, divisor, delay_cycles, width_cycles,
        input  strobe_out, busy, missed_cnt
    );

    modport slave (
        input  trig_in, enable, divisor, delay_cycles, width_cycles,
        output strobe_out, busy, missed_cnt
    );
endinterface

// File: rtl/strobe_pulse_gen.sv
// Fires one delayed, fixed-width strobe on every Nth camera trigger edge and counts
// triggers that land while a strobe sequence is still in flight.
//
// state | meaning
// IDLE  | waiting for an accepted trigger edge; divider advances here only
// DELAY | counting down the latched phase delay
// PULSE | strobe_out high, counting down the latched width
module strobe_pulse_gen #(
    parameter int CNT_W  = 32,
    parameter int MISS_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    strobe_pulse_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

    state_t            state;
    logic              trig_prev;
    logic [15:0]       div_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  width_l;
    logic              strobe_q;
    logic [MISS_W-1:0] missed_q;
    logic              trig_edge;
    logic [15:0]       eff_div;

    assign trig_edge = bus.trig_in & ~trig_prev;
    assign eff_div   = (bus.divisor == 16'd0) ? 16'd1 : bus.divisor;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            trig_prev <= 1'b1;
            div_cnt   <= 16'd0;
            cnt       <= '0;
            width_l   <= '0;
            strobe_q  <= 1'b0;
            missed_q  <= '0;
        end else begin
            trig_prev <= bus.trig_in;
            case (state)
                IDLE: begin
                    if (!bus.enable) begin
                        div_cnt <= 16'd0;
                    end else if (trig_edge) begin
                        // >= lets a divisor lowered mid-count fire on the next edge
                        if (div_cnt >= eff_div - 16'd1) begin
                            div_cnt <= 16'd0;
                            width_l <= bus.width_cycles;
                            if (bus.width_cycles != '0) begin
                                if (bus.delay_cycles == '0) begin
                                    state    <= PULSE;
                                    cnt      <= bus.width_cycles - CNT_ONE;
                                    strobe_q <= 1'b1;
                                end else begin
                                    state <= DELAY;
                                    cnt   <= bus.delay_cycles - CNT_ONE;
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 16'd1;
                        end
                    end
                end
                DELAY: begin
                    if (cnt == '0) begin
                        state    <= PULSE;
                        cnt      <= width_l - CNT_ONE;
                        strobe_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        strobe_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    strobe_q <= 1'b0;
                end
            endcase
            // edges while in flight are lost, including one in the final PULSE cycle
            if (state != IDLE && trig_edge && missed_q != '1) begin
                missed_q <= missed_q + MISS_ONE;
            end
        end
    end

    assign bus.strobe_out = strobe_q;
    assign bus.busy       = (state != IDLE);
    assign bus.missed_cnt = missed_q;
endmodule

// File: tb/tb_strobe_pulse_gen.sv
// Directed bench for strobe_pulse_gen: stimulus pushes expected strobe (start, width) pairs,
// a negedge monitor pops them as strobes appear; a second instance checks the 4-bit saturating counter.
module tb_strobe_pulse_gen;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    typedef struct {
        int start;
        int width;
    } exp_t;
    exp_t exp_q[$];

    strobe_pulse_gen_if #(.CNT_W(32), .MISS_W(16)) bus ();
    strobe_pulse_gen_if #(.CNT_W(32), .MISS_W(4))  sat ();

    strobe_pulse_gen #(.CNT_W(32), .MISS_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    strobe_pulse_gen #(.CNT_W(32), .MISS_W(4)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat.slave)
    );

    assign sat.trig_in      = bus.trig_in;
    assign sat.enable       = bus.enable;
    assign sat.divisor      = bus.divisor;
    assign sat.delay_cycles = bus.delay_cycles;
    assign sat.width_cycles = bus.width_cycles;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // advance to the negedge inside cycle c
    task automatic at(input int c);
        if (cyc > c) begin
            n_total++;
            $display("FAIL schedule: wanted cycle %0d, already at %0d", c, cyc);
        end
        while (cyc < c) @(negedge clk);
    endtask

    task automatic edge_at(input int e);
        at(e);
        bus.trig_in = 1'b1;
        @(negedge clk);
        bus.trig_in = 1'b0;
    endtask

    task automatic expect_strobe(input int start, input int width);
        exp_t x;
        x.start = start;
        x.width = width;
        exp_q.push_back(x);
    endtask

    // monitor
    logic s_prev = 1'b0;
    bit   have_cur = 1'b0;
    int   cur_start;
    exp_t cur;
    always @(negedge clk) begin
        if (bus.strobe_out === 1'b1 && s_prev !== 1'b1) begin
            cur_start = cyc;
            if (exp_q.size() == 0) begin
                n_total++;
                have_cur = 1'b0;
                $display("FAIL unexpected_strobe: rose at cycle %0d, none expected", cyc);
            end else begin
                cur = exp_q.pop_front();
                have_cur = 1'b1;
                chk("strobe_start", 64'(cyc), 64'(cur.start));
            end
        end else if (bus.strobe_out !== 1'b1 && s_prev === 1'b1 && have_cur) begin
            chk("strobe_width", 64'(cyc - cur_start), 64'(cur.width));
            have_cur = 1'b0;
        end
        s_prev = bus.strobe_out;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, base;
        reset            = 1'b1;
        bus.trig_in      = 1'b0;
        bus.enable       = 1'b1;
        bus.divisor      = 16'd1;
        bus.delay_cycles = 0;
        bus.width_cycles = 0;
        repeat (3) @(negedge clk);
        chk("reset_strobe", 64'(bus.strobe_out), 0);
        chk("reset_busy", 64'(bus.busy), 0);
        chk("reset_missed", 64'(bus.missed_cnt), 0);
        reset = 1'b0;

        // basic timing
        bus.delay_cycles = 5;
        bus.width_cycles = 3;
        e = cyc + 5;
        expect_strobe(e + 6, 3);
        at(e);
        chk("t1_busy_before", 64'(bus.busy), 0);
        edge_at(e);
        chk("t1_busy_first", 64'(bus.busy), 1);
        at(e + 8);
        chk("t1_busy_last", 64'(bus.busy), 1);
        at(e + 9);
        chk("t1_busy_after", 64'(bus.busy), 0);
        chk("t1_missed", 64'(bus.missed_cnt), 0);

        // zero delay, then zero width
        bus.delay_cycles = 0;
        bus.width_cycles = 1;
        e = cyc + 5;
        expect_strobe(e + 1, 1);
        edge_at(e);
        at(e + 3);
        bus.width_cycles = 0;
        e = cyc + 5;
        edge_at(e);
        chk("t2_w0_busy", 64'(bus.busy), 0);
        at(e + 3);
        chk("t2_w0_busy_late", 64'(bus.busy), 0);

        // divider
        bus.divisor      = 16'd3;
        bus.delay_cycles = 2;
        bus.width_cycles = 2;
        base = cyc + 5;
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 2) expect_strobe(base + 20 * i + 3, 2);
            edge_at(base + 20 * i);
        end
        at(base + 180);
        bus.divisor = 16'd0;
        base = cyc + 5;
        for (int i = 0; i < 3; i++) begin
            expect_strobe(base + 10 * i + 3, 2);
            edge_at(base + 10 * i);
        end
        at(base + 30);
        chk("t3_missed", 64'(bus.missed_cnt), 0);

        // missed edges, final-PULSE-cycle edge, saturation
        bus.divisor      = 16'd1;
        bus.delay_cycles = 100;
        bus.width_cycles = 50;
        base = cyc + 5;
        expect_strobe(base + 101, 50);
        for (int i = 0; i < 15; i++) edge_at(base + 10 * i);
        chk("t4_missed14", 64'(bus.missed_cnt), 14);
        edge_at(base + 150);
        chk("t4_missed_last_pulse", 64'(bus.missed_cnt), 15);
        chk("t4_idle_after_last", 64'(bus.busy), 0);
        chk("t4_sat15", 64'(sat.missed_cnt), 15);
        bus.delay_cycles = 20;
        bus.width_cycles = 10;
        base = cyc + 5;
        expect_strobe(base + 21, 10);
        for (int i = 0; i < 6; i++) edge_at(base + 5 * i);
        at(base + 32);
        chk("t4_missed20", 64'(bus.missed_cnt), 20);
        chk("t4_sat_hold", 64'(sat.missed_cnt), 15);

        // back-to-back restart on first IDLE cycle
        bus.delay_cycles = 0;
        bus.width_cycles = 2;
        e = cyc + 5;
        expect_strobe(e + 1, 2);
        expect_strobe(e + 4, 2);
        edge_at(e);
        edge_at(e + 3);
        at(e + 7);
        chk("t4_b2b_missed", 64'(bus.missed_cnt), 20);

        // latch during DELAY, enable drop in flight
        bus.delay_cycles = 5;
        bus.width_cycles = 3;
        e = cyc + 5;
        expect_strobe(e + 6, 3);
        edge_at(e);
        at(e + 2);
        bus.delay_cycles = 50;
        bus.width_cycles = 7;
        bus.enable       = 1'b0;
        at(e + 12);
        chk("t5_done", 64'(bus.busy), 0);

        // enable=0 ignores edges and clears divider
        bus.enable       = 1'b1;
        bus.divisor      = 16'd3;
        bus.delay_cycles = 1;
        bus.width_cycles = 1;
        base = cyc + 5;
        edge_at(base);
        bus.enable = 1'b0;
        for (int i = 1; i <= 5; i++) edge_at(base + 5 * i);
        chk("t5_dis_missed", 64'(bus.missed_cnt), 20);
        chk("t5_dis_busy", 64'(bus.busy), 0);
        bus.enable = 1'b1;
        edge_at(base + 40);
        edge_at(base + 45);
        expect_strobe(base + 52, 1);
        edge_at(base + 50);
        at(base + 56);

        // reset mid-PULSE, then trig held high through reset release
        bus.divisor      = 16'd1;
        bus.delay_cycles = 2;
        bus.width_cycles = 10;
        e = cyc + 5;
        expect_strobe(e + 3, 3);
        edge_at(e);
        at(e + 5);
        reset = 1'b1;
        at(e + 6);
        chk("t6_rst_strobe", 64'(bus.strobe_out), 0);
        chk("t6_rst_busy", 64'(bus.busy), 0);
        chk("t6_rst_missed", 64'(bus.missed_cnt), 0);
        bus.trig_in = 1'b1;
        at(e + 8);
        reset = 1'b0;
        at(e + 30);
        chk("t6_held_busy", 64'(bus.busy), 0);
        bus.trig_in = 1'b0;
        expect_strobe(e + 38, 10);
        edge_at(e + 35);
        at(e + 55);

        chk("final_queue_empty", 64'(exp_q.size()), 0);
        chk("final_strobe_low", 64'(bus.strobe_out), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/strobe_pulse_gen.md
Name: strobe_pulse_gen

Overview:
Downstream stage of the camera-rate generator in the strobe controller. It consumes the camera trigger tick and fires one strobe on every Nth trigger. The strobe starts after a programmable phase delay and lasts a programmable width, both in clk48 cycles. The output drives the strobe LED/GPIO directly. Triggers that arrive while a sequence is in flight are counted as missed.

Parameters:
CNT_W, 32, width of delay/width counters and their inputs
MISS_W, 16, width of saturating missed-trigger counter

Ports:
clk  input  1  system clock (clk48)
reset  input  1  synchronous, active-high reset
trig_in  input  1  camera trigger (level or pulse); rising edges detected internally
enable  input  1  1 = new sequences may start
divisor  input  16  fire on every Nth accepted edge; 0 treated as 1
delay_cycles  input  CNT_W  cycles from trigger edge to strobe start
width_cycles  input  CNT_W  strobe high time in cycles; 0 = suppressed
strobe_out  output  1  registered strobe pulse
busy  output  1  high whenever state != IDLE
missed_cnt  output  MISS_W  saturating count of edges arriving while busy

Behaviour:
- Clock and reset: single clock domain (clk). reset is synchronous and active-high.
- Reset values: state=IDLE, strobe_out=0, busy=0, missed_cnt=0, div_cnt=0, trig_prev=1. trig_prev=1 prevents an input already high at reset release from firing.
- Edge detect: edge = trig_in & ~trig_prev, where trig_prev is trig_in registered every cycle.
- States: IDLE, DELAY, PULSE. busy = (state != IDLE).
- IDLE, with edge and enable:
  - eff_div = (divisor==0) ? 1 : divisor.
  - If div_cnt >= eff_div-1: div_cnt<=0 and start a sequence. Using >= means a divisor lowered mid-count fires on the next edge.
  - Otherwise div_cnt<=div_cnt+1 and no start.
- Sequence start:
  - delay_cycles and width_cycles are latched at start. Later input changes do not affect an in-flight sequence.
  - width==0: stay in IDLE, strobe never asserts; counts as a consumed fire (div_cnt still reset).
  - delay==0 (width>0): PULSE, cnt<=width-1, strobe_out<=1.
  - delay>0 (width>0): DELAY, cnt<=delay-1.
- DELAY: if cnt==0, go to PULSE with cnt<=width_l-1 and strobe_out<=1; else cnt<=cnt-1.
- PULSE: if cnt==0, strobe_out<=0 and go to IDLE; else cnt<=cnt-1.
- Timing: with the edge sampled at cycle E, strobe_out is first high in cycle E+1+delay and stays high exactly width cycles.
- Edges in DELAY or PULSE:
  - Ignored for division.
  - missed_cnt<=missed_cnt+1, saturating at all-ones.
  - Includes an edge in the final PULSE cycle (cnt==0): that edge counts as missed, and a new sequence needs the next edge.
- enable=0:
  - In IDLE: edges are ignored (not missed) and div_cnt is held at 0.
  - In flight: an in-flight sequence completes normally.
- Back-to-back: the earliest possible restart is the edge sampled in the first IDLE cycle after PULSE ends. The minimum strobe low time is therefore 1 cycle.
- reset mid-sequence: strobe_out drops to 0 the cycle after reset is sampled; all state returns to reset values.
- Arithmetic: the counters are CNT_W wide, unsigned and never wrap. Decrements occur only when cnt>0.

Test Plan:
1. Basic timing: divisor=1, delay=5, width=3, one-cycle trig_in at cycle 10. Required: strobe_out high cycles 16-18 only; busy high cycles 11-18; missed_cnt=0.
2. Zero-delay / zero-width: delay=0, width=1, edge at cycle 10 gives strobe high in cycle 11 only. Repeat with width=0: strobe never asserts, busy stays 0.
3. Divider: divisor=3, delay=2, width=2, 9 edges spaced 20 cycles apart. Required: exactly 3 strobes, following edges 3, 6 and 9. divisor=0 behaves as 1 (every edge fires).
4. Missed / saturation:
   - delay=100, width=50, with edges every 10 cycles: after the first fire, the 14 edges inside the busy window raise missed_cnt to 14.
   - With MISS_W=4 and 20 missed edges, missed_cnt holds at 15.
5. Latch and enable: change delay from 5 to 50 during DELAY; the current strobe still starts at E+6. enable=0 with 5 edges gives no strobes, missed_cnt unchanged, and div_cnt restarting from 0 after re-enable.
6. Reset cases: assert reset during PULSE; strobe_out=0 next cycle and busy=0. Holding trig_in=1 through reset release gives no strobe until trig_in falls and rises again.
